div_hilo_ctrl: RTL and testbench
================================

// Module: div_hilo_ctrl
// PURPOSE
//  Sequencer between the EX stage and the iterative 32-bit divider. Accepts DIV/DIVU
//  issues, drives the divider start/ack/annul handshake, and owns the HI/LO registers.
//  Produces the pipeline stall and aborts cleanly on flush.
//  Short-circuits divide-by-zero and signed overflow without starting the divider.
// PARAMETERS
//  TIMEOUT   16            max RUN cycles waiting for div_ready before forced abort
//  ZERO_LO   32'hFFFFFFFF  LO value written for divide-by-zero (HI gets dividend)
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, asynchronous, active-high
//  issue_valid in   1   EX presents a divide this cycle
//  issue_sign  in   1   1=DIV (signed), 0=DIVU
//  issue_a     in   32  dividend
//  issue_b     in   32  divisor
//  issue_ready out  1   controller can accept issue / HI-LO write (state==IDLE)
//  flush       in   1   pipeline flush; kills an in-flight or offered divide
//  hilo_rd     in   1   EX wants to read HI or LO this cycle
//  wr_hi       in   1   MTHI write, data on wr_data
//  wr_lo       in   1   MTLO write, data on wr_data
//  wr_data     in   32  MTHI/MTLO data
//  stall_out   out  1   stall EX: (issue_valid|hilo_rd|wr_hi|wr_lo) & ~issue_ready
//  hi          out  32  HI register
//  lo          out  32  LO register
//  err         out  1   sticky: divider timed out; cleared only by rst
//  div_signed  out  1   to divider: signed mode (registered)
//  div_a       out  32  to divider: dividend (registered)
//  div_b       out  32  to divider: divisor (registered)
//  div_start   out  1   to divider: held high for the whole operation
//  div_ack     out  1   to divider enable: one-cycle pulse clearing its ready
//  div_annul   out  1   to divider: one-cycle abort pulse
//  div_result  in   64  from divider: {remainder, quotient}
//  div_ready   in   1   from divider: result valid
// BEHAVIOUR
//  Reset: state=IDLE; hi=lo=0; err=0; div_start=div_ack=div_annul=0; div_a=div_b=0;
//   div_signed=0; timeout counter=0. issue_ready=1 after reset.
//  States: IDLE, RUN, ACK, ABORT. All outputs registered except issue_ready, stall_out.
//  IDLE: issue_valid & ~flush -> latch operands. If issue_b==0: hi<=issue_a,
//   lo<=ZERO_LO, stay IDLE (1-cycle). Elif issue_sign & a==32'h80000000 & b==32'hFFFFFFFF:
//   lo<=32'h80000000, hi<=0, stay IDLE. Else div_start<=1, cnt<=0, ->RUN.
//   issue_valid & flush -> ignored. wr_hi/wr_lo in IDLE: update hi/lo next edge;
//   if issue accepted same cycle, the divide-by-zero/overflow write wins, else MT write applies.
//  RUN: div_start held 1, cnt increments each cycle.
//   flush (any cycle, incl. same cycle as div_ready) -> div_start<=0, div_annul<=1, ->ABORT;
//    HI/LO unchanged.
//   div_ready & ~flush -> hi<=div_result[63:32], lo<=div_result[31:0], div_start<=0,
//    ->ACK.
//   cnt==TIMEOUT-1 & ~div_ready -> err<=1, ->ABORT (as flush).
//  ACK: div_ack=1 for exactly this cycle, flush ignored (result committed) -> IDLE.
//  ABORT: div_annul=1 for exactly this cycle -> IDLE.
//  issue_ready=1 only in IDLE; new issue, HI/LO read and MT writes stall otherwise.
//  Latency (divider ready N cycles after start seen): result visible on hi/lo
//   N+1 cycles after issue accept; issue_ready returns 1 cycle later (ACK).
//  Reset mid-operation: everything to reset values immediately; divider shares rst.
// TESTING
//  DIVU a=100,b=7, divider model ready after 7 cycles -> hi=2, lo=14, one div_ack pulse, stall until IDLE.
//  DIV a=-7 (FFFFFFF9), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; div_signed=1 held during RUN.
//  DIV b=0, a=5 -> next cycle hi=5, lo=FFFFFFFF, div_start never asserted, no stall.
//  DIV a=80000000,b=FFFFFFFF -> lo=80000000, hi=0 in 1 cycle; flush coincident with div_ready -> annul pulse, HI/LO unchanged.
//  Model never asserts ready -> after 16 RUN cycles err=1, one div_annul pulse, IDLE; MTHI 0x1234 then hi=0x1234.

Source files
------------

// File: rtl/div_hilo_ctrl.sv
// Sequencer between EX and the iterative 32-bit divider; owns HI/LO.
// Latency: hi/lo valid N+1 cycles after issue accept (divider ready N cycles after start), idle 1 cycle later.
// Backpressure: issue_ready only in IDLE; issue, HI/LO read and MTHI/MTLO stall EX otherwise.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   issue_* / issue_ready     DIV/DIVU request from EX and acceptance
//   flush                     kills an offered or in-flight divide
//   hilo_rd, wr_hi, wr_lo,
//   wr_data                   HI/LO read request and MTHI/MTLO writes
//   stall_out                 EX stall
//   hi, lo, err               architectural HI/LO, sticky divider-timeout flag
//   div_*                     handshake with the divider (start/ack/annul, operands, result)
module div_hilo_ctrl #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] ZERO_LO = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_sign,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  output logic        issue_ready,
  input  logic        flush,
  input  logic        hilo_rd,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        stall_out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  output logic        div_ack,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready
);

  typedef enum logic [1:0] {IDLE, RUN, ACK, ABORT} state_t;

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          sgn_q, sgn_d;
  logic          start_q, start_d;
  logic          ack_q, ack_d;
  logic          annul_q, annul_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic accept, by_zero, ovf, short_cut, timeout;

  assign accept    = (state_q == IDLE) && issue_valid && !flush;
  assign by_zero   = (issue_b == 32'd0);
  assign ovf       = issue_sign && (issue_a == 32'h80000000) && (issue_b == 32'hFFFFFFFF);
  // Both special cases resolve in IDLE without ever touching the divider.
  assign short_cut = by_zero || ovf;
  assign timeout   = (cnt_q == CNT_LAST) && !div_ready;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      annul_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      annul_q <= annul_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept && !short_cut) state_d = RUN;
      // Flush beats a same-cycle div_ready: the result is dropped.
      RUN:   if (flush)          state_d = ABORT;
             else if (div_ready) state_d = ACK;
             else if (timeout)   state_d = ABORT;
      ACK:   state_d = IDLE;
      ABORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    start_d = start_q;
    ack_d   = 1'b0;
    annul_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (accept) begin
          a_d   = issue_a;
          b_d   = issue_b;
          sgn_d = issue_sign;
          // Short-cut results override a same-cycle MTHI/MTLO.
          if (by_zero) begin
            hi_d = issue_a;
            lo_d = ZERO_LO;
          end else if (ovf) begin
            hi_d = 32'd0;
            lo_d = 32'h80000000;
          end else begin
            start_d = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (flush) begin
          start_d = 1'b0;
          annul_d = 1'b1;
        end else if (div_ready) begin
          hi_d    = div_result[63:32];
          lo_d    = div_result[31:0];
          start_d = 1'b0;
          ack_d   = 1'b1;
        end else if (timeout) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign issue_ready = (state_q == IDLE);
  assign stall_out   = (issue_valid || hilo_rd || wr_hi || wr_lo) && !issue_ready;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign err         = err_q;
  assign div_signed  = sgn_q;
  assign div_a       = a_q;
  assign div_b       = b_q;
  assign div_start   = start_q;
  assign div_ack     = ack_q;
  assign div_annul   = annul_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
module tb_div_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_sign;
  logic [31:0] issue_a, issue_b;
  logic        issue_ready;
  logic        flush, hilo_rd, wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic        stall_out;
  logic [31:0] hi, lo;
  logic        err, div_signed;
  logic [31:0] div_a, div_b;
  logic        div_start, div_ack, div_annul;
  logic [63:0] div_result;
  logic        div_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Divider stand-in: ready model_n cycles after it first sees start; 0 = never.
  int       model_n = 0;
  int       m_cnt;

  div_hilo_ctrl dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_sign(issue_sign),
    .issue_a(issue_a), .issue_b(issue_b), .issue_ready(issue_ready),
    .flush(flush), .hilo_rd(hilo_rd), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_data(wr_data), .stall_out(stall_out), .hi(hi), .lo(lo), .err(err),
    .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
    .div_start(div_start), .div_ack(div_ack), .div_annul(div_annul),
    .div_result(div_result), .div_ready(div_ready)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt     <= 0;
      div_ready <= 1'b0;
    end else if (div_ack || div_annul) begin
      m_cnt     <= 0;
      div_ready <= 1'b0;
    end else if (div_start && !div_ready) begin
      m_cnt <= m_cnt + 1;
      if (model_n != 0 && m_cnt == model_n - 1) div_ready <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Issue one divide that goes to the divider, then watch it cycle by cycle
  // (cycle 0 = just after the accepting edge) until issue_ready returns.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] res, input int n, input bit flush_on_rdy,
                        output int t_idle, output int t_hilo, output int n_ack,
                        output int n_annul, output int n_start, output int n_bad);
    model_n    = n;
    div_result = res;
    t_idle = -1; t_hilo = -1; n_ack = 0; n_annul = 0; n_start = 0; n_bad = 0;
    @(negedge clk);
    issue_valid = 1'b1; issue_sign = sgn; issue_a = a; issue_b = b;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    hilo_rd     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (issue_ready) begin
        t_idle = i;
        break;
      end
      if (div_start) n_start++;
      if (div_ack)   n_ack++;
      if (div_annul) n_annul++;
      if (t_hilo < 0 && {hi, lo} == res) t_hilo = i;
      if (!stall_out) n_bad++;
      if (div_start && (div_signed !== sgn || div_a !== a || div_b !== b)) n_bad++;
      if (flush_on_rdy && div_ready) flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
    hilo_rd = 1'b0;
  endtask

  int t_idle, t_hilo, n_ack, n_annul, n_start, n_bad;

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_sign = 1'b0; issue_a = '0; issue_b = '0;
    flush = 1'b0; hilo_rd = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    div_result = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hilo",  {hi, lo}, 64'd0);
    check("rst_err",   err, 1'b0);
    check("rst_ready", issue_ready, 1'b1);
    check("rst_ctl",   {div_start, div_ack, div_annul, div_signed}, 4'b0000);
    check("rst_ops",   {div_a, div_b}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // DIVU 100/7: quotient 14, remainder 2; divider ready after 7 cycles.
    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 7, 1'b0,
           t_idle, t_hilo, n_ack, n_annul, n_start, n_bad);
    check("divu_hilo_time", t_hilo, 8);
    check("divu_idle_time", t_idle, 9);
    check("divu_ack_cnt",   n_ack, 1);
    check("divu_annul_cnt", n_annul, 0);
    check("divu_start_cyc", n_start, 8);
    check("divu_stall_ops", n_bad, 0);
    check("divu_hi", hi, 32'd2);
    check("divu_lo", lo, 32'd14);

    // DIV -7/2: quotient -3, remainder -1.
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 3, 1'b0,
           t_idle, t_hilo, n_ack, n_annul, n_start, n_bad);
    check("div_neg_hilo_time", t_hilo, 4);
    check("div_neg_signed_ops", n_bad, 0);
    check("div_neg_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});

    // Divide by zero, with a same-cycle MTLO that must lose.
    model_n = 3;
    @(negedge clk);
    issue_valid = 1'b1; issue_sign = 1'b1; issue_a = 32'd5; issue_b = 32'd0;
    wr_lo = 1'b1; wr_data = 32'hABCD;
    #1;
    check("dz_no_stall", stall_out, 1'b0);
    @(posedge clk); #1;
    issue_valid = 1'b0; wr_lo = 1'b0;
    check("dz_hilo",  {hi, lo}, {32'd5, 32'hFFFFFFFF});
    check("dz_ready", issue_ready, 1'b1);
    check("dz_start", div_start, 1'b0);

    // Signed overflow short-cut.
    @(negedge clk);
    issue_valid = 1'b1; issue_sign = 1'b1; issue_a = 32'h80000000; issue_b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    check("ovf_hilo",  {hi, lo}, {32'd0, 32'h80000000});
    check("ovf_start", {div_start, issue_ready}, 2'b01);

    // Flush in the same cycle as div_ready: annul, HI/LO untouched.
    run_op(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 4, 1'b1,
           t_idle, t_hilo, n_ack, n_annul, n_start, n_bad);
    check("flush_annul_cnt", n_annul, 1);
    check("flush_ack_cnt",   n_ack, 0);
    check("flush_idle_time", t_idle, 6);
    check("flush_hilo",      {hi, lo}, {32'd0, 32'h80000000});

    // Offered issue killed by flush in IDLE.
    @(negedge clk);
    issue_valid = 1'b1; issue_sign = 1'b0; issue_a = 32'd9; issue_b = 32'd3; flush = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ignored", {div_start, issue_ready}, 2'b01);

    // Divider never ready: timeout after 16 RUN cycles.
    run_op(1'b0, 32'd1, 32'd1, {32'd0, 32'd1}, 0, 1'b0,
           t_idle, t_hilo, n_ack, n_annul, n_start, n_bad);
    check("to_start_cyc",  n_start, 16);
    check("to_annul_cnt",  n_annul, 1);
    check("to_idle_time",  t_idle, 17);
    check("to_err",        err, 1'b1);
    check("to_hilo",       {hi, lo}, {32'd0, 32'h80000000});

    // MTHI.
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'h1234;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    check("mthi", hi, 32'h1234);
    check("err_sticky", err, 1'b1);

    // Reset in the middle of a divide.
    model_n = 0;
    @(negedge clk);
    issue_valid = 1'b1; issue_sign = 1'b0; issue_a = 32'd8; issue_b = 32'd2;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    check("mid_running", div_start, 1'b1);
    rst = 1'b1; #1;
    check("mid_rst_ctl", {div_start, issue_ready, err}, 3'b010);
    check("mid_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
